regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2).
REQ-003 SHALL have parameter NRD, default 2, read port count (1..4).
REQ-004 SHALL derive localparam AW = $clog2(NREGS).
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-008 SHALL have port rd_data  out  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN].
REQ-009 SHALL have port wr_en  in  1  writeback enable.
REQ-010 SHALL have port wr_addr  in  AW  writeback destination.
REQ-011 SHALL have port wr_data  in  XLEN  writeback data.
REQ-012 SHALL have port iss_valid  in  1  decoder presents an instruction.
REQ-013 SHALL have port iss_rs1, iss_rs2  in  AW each  instruction sources.
REQ-014 SHALL have port iss_rd  in  AW  instruction destination.
REQ-015 SHALL have port iss_rd_en  in  1  instruction writes iss_rd.
REQ-016 SHALL have port iss_ready  out  1  instruction may issue this cycle.
REQ-017 SHALL have port busy  out  NREGS  pending-write bit per register.

Function
REQ-018 Register 0 SHALL read as zero; writes to it ignored; busy[0] constantly 0.
REQ-019 Reads SHALL be combinational; when wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal wr_data same cycle (write-through bypass).
REQ-020 Write SHALL commit at the rising edge when wr_en=1 and wr_addr!=0, regardless of busy state.
REQ-021 Effective busy eb[r] = busy[r] & ~(wr_en & wr_addr==r) (writeback this cycle resolves hazard).
REQ-022 iss_ready SHALL = ~eb[iss_rs1] & ~eb[iss_rs2] & ~(iss_rd_en & eb[iss_rd]) (RAW and WAW stall); combinational, independent of iss_valid.
REQ-023 Issue fires when iss_valid & iss_ready; on fire with iss_rd_en=1 and iss_rd!=0, busy[iss_rd] SHALL set at next edge.
REQ-024 wr_en with wr_addr!=0 SHALL clear busy[wr_addr] at next edge.
REQ-025 Same-edge set and clear of one register: set SHALL win.
REQ-026 Issue-to-operand-visibility latency: producer writeback data available to dependent read in the writeback cycle (0-cycle via bypass); dependent iss_ready rises that same cycle.
REQ-027 Source register 0 SHALL never stall.
REQ-028 Multiple read ports addressing same register SHALL return identical data.

Reset
REQ-029 When rst=1 at a rising edge, all registers SHALL become 0 and busy SHALL become all-zero; any same-cycle write or issue discarded.
REQ-030 During and after reset, iss_ready SHALL be 1 and rd_data all zero until a write commits.
REQ-031 Reset mid-stall SHALL release the stall on the following cycle.

Structure
REQ-032 Package rf_pkg SHALL hold XLEN, NREGS defaults and the AW derivation function.
REQ-033 Busy-bit logic SHALL be a sub-module rf_scoreboard (NREGS, AW parameters; set/clear ports, busy out); storage and bypass stay in top.

Verification
REQ-034 Write x1=10, x2=15 on consecutive cycles, then read rd_addr={x2,x1} -> rd_data={15,10}.
REQ-035 Write x0=0xDEAD, read x0 -> 0; issue iss_rd=0 -> busy stays 0.
REQ-036 Issue rd=x3 (fire); next cycle present rs1=x3 -> iss_ready=0; assert wr_en x3=0x55 -> same cycle iss_ready=1 and rd_data[0]=0x55.
REQ-037 x4 busy; issue rd=x4 in cycle with wr_en x4 -> iss_ready=1, busy[4]=1 after edge (set wins).
REQ-038 Set busy x5,x6, assert rst one cycle -> busy=0, all reads 0, iss_ready=1.
REQ-039 Parameter sweep NREGS=16, NRD=3, XLEN=64: repeat REQ-034/036 with 64-bit data 0x0123456789ABCDEF.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and address-width helper for the register file with
// write-back scoreboard.
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int addr_width(input int nregs);
      return $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracker: one busy bit per architectural register, set on
// issue and cleared on writeback, with set taking priority on the same edge.
module rf_scoreboard #(
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   output logic [NREGS-1:0] busy
);

   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;

   // Next busy vector; register 0 can never be pending.
   always_comb begin
      busy_nxt_s = busy_r;
      for (int r = 1; r < NREGS; r++) begin
         if (set_en && (set_addr == AW'(r))) begin
            busy_nxt_s[r] = 1'b1;
         end else if (clr_en && (clr_addr == AW'(r))) begin
            busy_nxt_s[r] = 1'b0;
         end else begin
            busy_nxt_s[r] = busy_r[r];
         end
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy = busy_r;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and a RAW/WAW issue
// gate driven by per-register pending-write bits.
module regfile_scoreboard
   import rf_pkg::*;
#(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   parameter  int NRD   = 2,
   localparam int AW    = addr_width(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rs1,
   input  logic [AW-1:0]       iss_rs2,
   input  logic [AW-1:0]       iss_rd,
   input  logic                iss_rd_en,
   output logic                iss_ready,
   output logic [NREGS-1:0]    busy
);

   logic [XLEN-1:0]  regs_r [NREGS];
   logic [NREGS-1:0] busy_s;
   logic [NREGS-1:0] wr_hit_s;
   logic [NREGS-1:0] eb_s;
   logic             wr_commit_s;
   logic             fire_s;
   logic             set_en_s;

   assign wr_commit_s = wr_en && (wr_addr != '0);

   // One-hot of the register being written back this cycle.
   always_comb begin
      wr_hit_s = '0;
      for (int r = 1; r < NREGS; r++) begin
         if (wr_en && (wr_addr == AW'(r))) begin
            wr_hit_s[r] = 1'b1;
         end else begin
            wr_hit_s[r] = 1'b0;
         end
      end
   end

   // A writeback landing this cycle already resolves its hazard.
   assign eb_s      = busy_s & ~wr_hit_s;
   assign iss_ready = ~eb_s[iss_rs1] & ~eb_s[iss_rs2] & ~(iss_rd_en & eb_s[iss_rd]);
   assign fire_s    = iss_valid && iss_ready;
   assign set_en_s  = fire_s && iss_rd_en && (iss_rd != '0);

   // Combinational reads with zero register and write-through bypass.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NRD; i++) begin
         if (rd_addr[i*AW +: AW] == '0) begin
            rd_data[i*XLEN +: XLEN] = '0;
         end else if (wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data;
         end else begin
            rd_data[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
         end
      end
   end

   // Register storage; entry 0 is held at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_r[r] <= '0;
         end
      end else if (wr_commit_s) begin
         regs_r[wr_addr] <= wr_data;
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (set_en_s),
      .set_addr (iss_rd),
      .clr_en   (wr_commit_s),
      .clr_addr (wr_addr),
      .busy     (busy_s)
   );

   assign busy = busy_s;

endmodule
